hazard_scoreboard_unit: RTL

Parametrised load-use hazard detector for the in-order pipeline, successor to the single-cycle load-use check. It keeps a per-register scoreboard so memory read latencies longer than one cycle are supported. It also qualifies each source operand with a "used" flag, can exempt a hardwired zero register, gives branch flushes priority over stalls, and counts stall cycles. It sits beside the ID stage and drives the PC, IF/ID and ID/EX pipeline controls.

---
 rtl/hazard_scoreboard_unit.sv | 74 +++++++
 1 files changed

// File: rtl/hazard_scoreboard_unit.sv
// rtl/hazard_scoreboard_unit.sv - per-register load-use scoreboard with flush priority and stall counter
// Drives PC, IF/ID and ID/EX controls from the ID-stage source operands.
module hazard_scoreboard_unit #(
  parameter int REG_ADDR_W  = 2,
  parameter int LOAD_LAT    = 1,
  parameter int ZERO_REG_EN = 0,
  parameter int CNT_W       = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ex_mem_read,
  input  logic                  ex_reg_write,
  input  logic [REG_ADDR_W-1:0] ex_wr_addr,
  input  logic [REG_ADDR_W-1:0] id_rs_addr,
  input  logic [REG_ADDR_W-1:0] id_rt_addr,
  input  logic                  id_rs_used,
  input  logic                  id_rt_used,
  input  logic                  flush,
  output logic                  stall,
  output logic                  pc_write_en,
  output logic                  if_id_write_en,
  output logic                  id_ex_bubble,
  output logic [CNT_W-1:0]      stall_count
);

  localparam int         NREG    = 1 << REG_ADDR_W;
  localparam logic [2:0] SET_VAL = 3'(LOAD_LAT - 1);

  logic [2:0] busy_cnt [NREG];
  logic       load_in_ex;
  logic       hazard_rs;
  logic       hazard_rt;

  function automatic logic is_zero_reg(input logic [REG_ADDR_W-1:0] addr);
    return (ZERO_REG_EN != 0) && (addr == '0);
  endfunction

  assign load_in_ex = ex_mem_read & ex_reg_write;

  // A source conflicts with the load currently in EX or with one still owed cycles.
  always_comb begin
    hazard_rs = 1'b0;
    hazard_rt = 1'b0;
    if (id_rs_used && !is_zero_reg(id_rs_addr))
      hazard_rs = (load_in_ex && (ex_wr_addr == id_rs_addr)) || (busy_cnt[id_rs_addr] != 3'd0);
    if (id_rt_used && !is_zero_reg(id_rt_addr))
      hazard_rt = (load_in_ex && (ex_wr_addr == id_rt_addr)) || (busy_cnt[id_rt_addr] != 3'd0);
  end

  assign stall          = ~rst & ~flush & (hazard_rs | hazard_rt);
  assign pc_write_en    = ~stall;
  assign if_id_write_en = ~stall;
  assign id_ex_bubble   = stall;

  // Loads are recorded regardless of flush: the EX instruction predates the branch.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < NREG; r++) busy_cnt[r] <= 3'd0;
      stall_count <= '0;
    end else begin
      for (int r = 0; r < NREG; r++) begin
        if (load_in_ex && (ex_wr_addr == REG_ADDR_W'(r)) && !is_zero_reg(REG_ADDR_W'(r)))
          busy_cnt[r] <= SET_VAL;
        else if (ex_reg_write && !ex_mem_read && (ex_wr_addr == REG_ADDR_W'(r)))
          busy_cnt[r] <= 3'd0;
        else if (busy_cnt[r] != 3'd0)
          busy_cnt[r] <= busy_cnt[r] - 3'd1;
      end
      if (stall && (stall_count != {CNT_W{1'b1}}))
        stall_count <= stall_count + 1'b1;
    end
  end

endmodule
